// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Collects a three-byte command (header, A, B) from a valid/ready byte
// stream, presents it to an external registered ALU, pulses the ALU enable
// once, waits LATENCY cycles for the ALU result and offers the captured
// result on a valid/ready output port. A counter tracks delivered results.
//
// Parameters
//   LATENCY    ALU cycles from alu_ena pulse to valid alu_y/alu_flag (1..7)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    command byte stream (header, A, B)
//   in_valid   in_data valid
//   in_ready   sequencer accepts a byte this cycle
//   alu_ui     to ALU ui_in  : {A[7:3], op[2:0]}
//   alu_uio    to ALU uio_in : B (shift amount = B[2:0])
//   alu_ena    ALU register enable, one-cycle pulse per command
//   alu_y      ALU registered result
//   alu_flag   ALU registered carry/borrow flag
//   res_data   captured result
//   res_flag   captured flag
//   res_valid  result available
//   res_ready  consumer accepts result
//   res_count  completed-result counter (wraps 0xFF -> 0x00)
//
// Configuration
//   ALU_SEQ_CHAIN_EN  when defined, a header with bit 3 set skips the A byte
//                     and reuses the last captured result as A (only once a
//                     result has been captured since reset). When undefined,
//                     header bit 3 is ignored and every command is 3 bytes.
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] alu_ui,
    output logic [7:0] alu_uio,
    output logic       alu_ena,
    input  logic [7:0] alu_y,
    input  logic       alu_flag,
    output logic [7:0] res_data,
    output logic       res_flag,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t     state;
    logic [2:0] op_q;
    logic [7:3] a_q;        // only A[7:3] reaches the ALU; op occupies [2:0]
    logic [2:0] wait_cnt;
    logic       in_xfer;

`ifdef ALU_SEQ_CHAIN_EN
    // Set once a result has been captured; res_data then doubles as the
    // accumulator, so no separate last-result register is needed.
    logic       have_result;
`endif

    // Decoded straight from the state register so the port reads 1 in the
    // very first cycle after reset is released; gating with rst keeps it low
    // while reset is asserted.
    assign in_ready = !rst && (state == IDLE || state == GET_A || state == GET_B);
    assign in_xfer  = in_valid && in_ready;

    // NOTE: every register below is updated with non-blocking assignments so
    // all next-state values are computed from the pre-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= 3'd0;
            a_q       <= 5'd0;
            wait_cnt  <= 3'd0;
            alu_ui    <= 8'h00;
            alu_uio   <= 8'h00;
            alu_ena   <= 1'b0;
            res_data  <= 8'h00;
            res_flag  <= 1'b0;
            res_valid <= 1'b0;
            res_count <= 8'h00;
`ifdef ALU_SEQ_CHAIN_EN
            have_result <= 1'b0;
`endif
        end else begin
            // alu_ena is a single-cycle pulse: raised only on entry to ISSUE.
            alu_ena <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        op_q  <= in_data[2:0];
                        state <= GET_A;
`ifdef ALU_SEQ_CHAIN_EN
                        if (in_data[3] && have_result) begin
                            a_q   <= res_data[7:3];
                            state <= GET_B;
                        end
`endif
                    end
                end

                GET_A: begin
                    if (in_xfer) begin
                        a_q   <= in_data[7:3];
                        state <= GET_B;
                    end
                end

                GET_B: begin
                    if (in_xfer) begin
                        // Operands are loaded together with the enable and
                        // held until the next command reaches ISSUE.
                        alu_ui  <= {a_q, op_q};
                        alu_uio <= in_data;
                        alu_ena <= 1'b1;
                        state   <= ISSUE;
                    end
                end

                ISSUE: begin
                    wait_cnt <= 3'(LATENCY);
                    state    <= WAIT;
                end

                WAIT: begin
                    // Counter reaches 1 in the cycle the ALU output is valid.
                    if (wait_cnt == 3'd1) begin
                        res_data  <= alu_y;
                        res_flag  <= alu_flag;
                        res_valid <= 1'b1;
                        state     <= DONE;
`ifdef ALU_SEQ_CHAIN_EN
                        have_result <= 1'b1;
`endif
                    end
                    wait_cnt <= wait_cnt - 3'd1;
                end

                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_count <= res_count + 8'd1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: LATENCY, 1, ALU cycles from alu_ena pulse to valid alu_y/alu_flag (legal 1..7).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_data  in  8  command byte stream (header, A, B).
REQ-005 in_valid  in  1  in_data valid.
REQ-006 in_ready  out  1  sequencer accepts byte; transfer = in_valid & in_ready.
REQ-007 alu_ui  out  8  to ALU ui_in: {A[7:3], op[2:0]}.
REQ-008 alu_uio  out  8  to ALU uio_in: B (shamt = B[2:0]).
REQ-009 alu_ena  out  1  ALU register enable; one-cycle pulse per command.
REQ-010 alu_y  in  8  ALU registered result.
REQ-011 alu_flag  in  1  ALU registered carry/borrow flag.
REQ-012 res_data  out  8  captured result.
REQ-013 res_flag  out  1  captured flag.
REQ-014 res_valid  out  1  result available; transfer = res_valid & res_ready.
REQ-015 res_ready  in  1  consumer accepts result.
REQ-016 res_count  out  8  completed-result counter.

Function
REQ-017 FSM states: IDLE, GET_A, GET_B, ISSUE, WAIT, DONE.
REQ-018 in_ready = 1 only in IDLE, GET_A, GET_B; 0 in ISSUE, WAIT, DONE.
REQ-019 IDLE: header accepted -> latch op = in_data[2:0], chain = in_data[3]; next GET_A (GET_B if chain taken, REQ-033); in_data[7:4] ignored.
REQ-020 GET_A: byte accepted -> latch A, next GET_B; GET_B: byte accepted -> latch B, next ISSUE; no transfer -> hold state.
REQ-021 ISSUE: alu_ena = 1 for exactly one cycle, next WAIT; alu_ena = 0 in every other state.
REQ-022 alu_ui/alu_uio stable from ISSUE until capture; A[2:0] overwritten by op in alu_ui.
REQ-023 WAIT: down-counter loaded with LATENCY on ISSUE; at counter = 1 the sequencer captures alu_y/alu_flag into res_data/res_flag and enters DONE (capture = ISSUE cycle + LATENCY).
REQ-024 DONE: res_valid = 1; res_data/res_flag held stable until res_ready; on transfer -> IDLE, res_valid 0 next cycle.
REQ-025 Header-to-res_valid latency with zero input stalls: 3 accept cycles + 1 ISSUE + LATENCY cycles.
REQ-026 Op 3'b111 (reserved) issued normally; result is whatever ALU returns (0).
REQ-027 res_count increments by 1 on each result transfer; wraps 0xFF -> 0x00.
REQ-028 in_valid outside accepting states ignored, no byte consumed.

Reset
REQ-029 rst sampled high at clk edge -> state IDLE, alu_ui/alu_uio/res_data/res_count = 0x00, alu_ena/res_flag/res_valid = 0, WAIT counter 0, chain register cleared.
REQ-030 in_ready = 0 during the reset cycle, 1 the first cycle after rst deasserts.
REQ-031 Reset mid-command (any state) abandons it: no res_valid, res_count unchanged from 0, partial bytes discarded.

Configuration
REQ-032 Macro ALU_SEQ_CHAIN_EN selects accumulator chaining.
REQ-033 Defined: header bit3 = 1 with a prior result captured since reset -> skip GET_A, A = last res_data; bit3 = 1 with no prior result -> GET_A as normal.
REQ-034 Undefined: header bit3 ignored, every command takes three bytes; no last-result storage synthesized.

Verification
REQ-035 LATENCY=1; bytes 0x00, 0xF0, 0x20 -> alu_ui 0xF0, alu_uio 0x20, single alu_ena pulse; res_data 0x10, res_flag 1, res_valid 5 cycles after header accept.
REQ-036 Bytes 0x06, 0x50, 0x06 (SUB) -> alu_ui 0x56; res_data 0x50, res_flag 0; res_count 0x00 -> 0x01 on transfer.
REQ-037 ALU_SEQ_CHAIN_EN defined; after result 0x10, bytes 0x09, 0x0F -> alu_ui 0x11 (OR), res_data 0x1F, only two bytes consumed.
REQ-038 res_ready low 5 cycles in DONE -> res_data/res_flag/res_valid stable, in_ready 0, alu_ena 0; transfer on 6th cycle -> IDLE.
REQ-039 rst pulsed in WAIT -> no res_valid, all outputs 0x00/0, in_ready 1 next cycle; following command completes normally.
REQ-040 256 commands completed -> res_count wraps to 0x00.
